ps2_keyboard_rx: RTL and testbench

Single-clock PS/2 keyboard receiver: synchronises and debounces kbd_clk/kbd_data, deframes 11-bit PS/2 frames with odd-parity and stop-bit checking, and recovers from aborted frames by timeout. Optionally folds E0/F0 prefixes into extended/break flags. Buffers key events in a FIFO with a ready/valid pop interface for the keyboard-matrix/ULA side of the design.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_clk_filter.sv | 58 +++++
 rtl/ps2_keyboard_rx.sv | 198 +++++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

   // Scan-code prefixes that qualify the following byte
   localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
   localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

   // Frame deserialiser states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_t;

   // One key event as stored in the FIFO (10 bits)
   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ps2_event_t;

   // PS/2 uses odd parity: data bits plus parity bit must XOR to 1
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronises kbd_clk/kbd_data, debounces kbd_clk and emits a one-cycle
// strobe on each filtered falling edge. Everything idles high after reset.
module ps2_clk_filter #(
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic kbd_clk,
   input  logic kbd_data,
   output logic fall_strobe,
   output logic data_sync
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [1:0]    clk_sync_q;
   logic [1:0]    data_sync_q;
   logic          clk_prev_q;
   logic          filt_q;
   logic          strobe_q;
   logic [CW-1:0] cnt_q;

   // Two-flop synchronisers, preset to the idle-high bus level
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], kbd_clk};
         data_sync_q <= {data_sync_q[0], kbd_data};
      end
   end

   // Stability counter; filtered clock follows only after a quiet period
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_prev_q <= 1'b1;
         cnt_q      <= '0;
         filt_q     <= 1'b1;
         strobe_q   <= 1'b0;
      end else begin
         clk_prev_q <= clk_sync_q[1];
         strobe_q   <= 1'b0;
         if (clk_sync_q[1] != clk_prev_q) begin
            cnt_q <= '0;
         end else if (cnt_q != CW'(DEBOUNCE_CYCLES)) begin
            cnt_q <= cnt_q + 1'b1;
         end else begin
            filt_q   <= clk_prev_q;
            strobe_q <= filt_q & ~clk_prev_q;
         end
      end
   end

   assign fall_strobe = strobe_q;
   assign data_sync   = data_sync_q[1];

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: deframes 11-bit frames, folds E0/F0 prefixes
// into flags (when DECODE=1) and queues key events in a FWFT FIFO.
//
// Pop handshake: the head event is transferred on every clk edge where
// key_valid && key_ready are both high; key_valid never depends on
// key_ready, and the head fields stay stable until popped.
module ps2_keyboard_rx
   import ps2_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int TIMEOUT_CYCLES  = 100000,
   parameter int FIFO_DEPTH      = 8,
   parameter int DECODE          = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       kbd_clk,
   input  logic       kbd_data,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic       key_break,
   output logic       key_valid,
   input  logic       key_ready,
   output logic       overflow,
   output logic       parity_err,
   output logic       frame_err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int AW = $clog2(FIFO_DEPTH);

   logic fall_stb;
   logic data_s;

   ps2_clk_filter #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_filt (
      .clk        (clk),
      .rst        (rst),
      .kbd_clk    (kbd_clk),
      .kbd_data   (kbd_data),
      .fall_strobe(fall_stb),
      .data_sync  (data_s)
   );

   // ---------------- deframer ----------------
   ps2_state_t    state_q;
   logic [2:0]    bit_cnt_q;
   logic [7:0]    shift_q;
   logic          par_ok_q;
   logic [TW-1:0] to_cnt_q;
   logic          acc_q;
   logic          parity_err_q;
   logic          frame_err_q;

   // Frame FSM: steps on each falling-edge strobe, aborts on a stalled bus
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         par_ok_q     <= 1'b0;
         to_cnt_q     <= '0;
         acc_q        <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         acc_q        <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;

         if (state_q == IDLE || fall_stb) begin
            to_cnt_q <= '0;
         end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
         end

         if (state_q != IDLE && !fall_stb && to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            frame_err_q <= 1'b1;
            state_q     <= IDLE;
         end else if (fall_stb) begin
            case (state_q)
               IDLE: begin
                  if (!data_s) begin
                     state_q   <= DATA;
                     bit_cnt_q <= '0;
                  end
               end
               DATA: begin
                  shift_q   <= {data_s, shift_q[7:1]};
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  if (bit_cnt_q == 3'd7) state_q <= PARITY;
               end
               PARITY: begin
                  par_ok_q <= odd_parity_ok(shift_q, data_s);
                  state_q  <= STOP;
               end
               STOP: begin
                  // A bad stop bit outranks a parity fault
                  if (!data_s)        frame_err_q  <= 1'b1;
                  else if (!par_ok_q) parity_err_q <= 1'b1;
                  else                acc_q        <= 1'b1;
                  state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   // ---------------- prefix decoder ----------------
   logic       ext_q;
   logic       brk_q;
   logic       push;
   ps2_event_t push_ev;

   // Event to enqueue for an accepted byte; prefixes are absorbed when decoding
   always_comb begin
      push    = 1'b0;
      push_ev = '0;
      if (DECODE != 0) begin
         push    = acc_q && (shift_q != PS2_PFX_EXT) && (shift_q != PS2_PFX_BRK);
         push_ev = '{ext: ext_q, brk: brk_q, code: shift_q};
      end else begin
         push    = acc_q;
         push_ev = '{ext: 1'b0, brk: 1'b0, code: shift_q};
      end
   end

   // Prefix flags: set by E0/F0, cleared by any pushed event or frame error
   always_ff @(posedge clk) begin
      if (rst) begin
         ext_q <= 1'b0;
         brk_q <= 1'b0;
      end else if (parity_err_q || frame_err_q) begin
         ext_q <= 1'b0;
         brk_q <= 1'b0;
      end else if (acc_q && DECODE != 0) begin
         if (shift_q == PS2_PFX_EXT) begin
            ext_q <= 1'b1;
         end else if (shift_q == PS2_PFX_BRK) begin
            brk_q <= 1'b1;
         end else begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
         end
      end
   end

   // ---------------- event FIFO ----------------
   ps2_event_t mem_q [FIFO_DEPTH];
   logic [AW:0] wr_ptr_q;
   logic [AW:0] rd_ptr_q;
   logic [AW:0] rd_ptr_d;
   logic        full;
   logic        pop;
   logic        wr_en;
   logic        key_valid_q;
   logic        overflow_q;
   ps2_event_t  head_q;

   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop      = key_valid_q && key_ready;
   // A pop frees the slot the new word lands in, so a full FIFO still accepts it
   assign wr_en    = push && (!full || pop);
   assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

   // Storage array, written at the tail pointer
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_ev;
   end

   // Pointers, registered head/valid and sticky overflow
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         key_valid_q <= 1'b0;
         head_q      <= '0;
         overflow_q  <= 1'b0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         rd_ptr_q    <= rd_ptr_d;
         key_valid_q <= (wr_ptr_q != rd_ptr_d);
         if (wr_ptr_q != rd_ptr_d) head_q <= mem_q[rd_ptr_d[AW-1:0]];
         if (push && full && !pop) overflow_q <= 1'b1;
      end
   end

   assign key_code   = head_q.code;
   assign key_ext    = head_q.ext;
   assign key_break  = head_q.brk;
   assign key_valid  = key_valid_q;
   assign overflow   = overflow_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: bit-level PS/2 driver, pop monitor,
// expected-event queues and pulse counters.
module tb_ps2_keyboard_rx;
   import ps2_pkg::*;

   localparam int DB   = 20;
   localparam int TO   = 3000;
   localparam int FD   = 8;
   localparam int HALF = 50;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rst2 = 1'b1;
   logic       kbd_clk = 1'b1;
   logic       kbd_data = 1'b1;
   logic       key_ready = 1'b1;
   logic       key_ready2 = 1'b1;

   logic [7:0] key_code, key_code2;
   logic       key_ext, key_ext2, key_break, key_break2;
   logic       key_valid, key_valid2, overflow, overflow2;
   logic       parity_err, parity_err2, frame_err, frame_err2;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   ps2_keyboard_rx #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(FD), .DECODE(1)) dut (
      .clk(clk), .rst(rst), .kbd_clk(kbd_clk), .kbd_data(kbd_data),
      .key_code(key_code), .key_ext(key_ext), .key_break(key_break),
      .key_valid(key_valid), .key_ready(key_ready), .overflow(overflow),
      .parity_err(parity_err), .frame_err(frame_err)
   );

   ps2_keyboard_rx #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(FD), .DECODE(0)) dut2 (
      .clk(clk), .rst(rst2), .kbd_clk(kbd_clk), .kbd_data(kbd_data),
      .key_code(key_code2), .key_ext(key_ext2), .key_break(key_break2),
      .key_valid(key_valid2), .key_ready(key_ready2), .overflow(overflow2),
      .parity_err(parity_err2), .frame_err(frame_err2)
   );

   // ---------------- scoreboard state ----------------
   logic [9:0] exp_q[$];
   logic [9:0] got_q[$];
   logic [9:0] exp2_q[$];
   logic [9:0] got2_q[$];
   int n_cmp = 0;
   int n_bad = 0;
   int valid_cycles = 0;
   int perr_cnt = 0;
   int ferr_cnt = 0;
   int stb_cnt = 0;
   int stb_snap = 0;
   int pop_wait = 0;

   // Monitor sampled on the falling clk edge
   always @(negedge clk) begin
      if (!rst) begin
         if (key_valid && key_ready) got_q.push_back({key_ext, key_break, key_code});
         if (key_valid)  valid_cycles++;
         if (parity_err) perr_cnt++;
         if (frame_err)  ferr_cnt++;
         if (dut.fall_stb) stb_cnt++;
      end
      if (!rst2 && key_valid2 && key_ready2) got2_q.push_back({key_ext2, key_break2, key_code2});
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_events(input string tag, input bit second);
      logic [31:0] g;
      logic [31:0] e;
      if (!second) begin
         check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
         while (exp_q.size() > 0) begin
            e = 32'(exp_q.pop_front());
            g = (got_q.size() > 0) ? 32'(got_q.pop_front()) : 32'hDEAD_BEEF;
            check(tag, g, e);
         end
         got_q.delete();
      end else begin
         check({tag, "_count"}, 32'(got2_q.size()), 32'(exp2_q.size()));
         while (exp2_q.size() > 0) begin
            e = 32'(exp2_q.pop_front());
            g = (got2_q.size() > 0) ? 32'(got2_q.pop_front()) : 32'hDEAD_BEEF;
            check(tag, g, e);
         end
         got2_q.delete();
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      kbd_data = b;
      cycles(HALF / 2);
      kbd_clk = 1'b0;
      cycles(HALF);
      kbd_clk = 1'b1;
      cycles(HALF / 2);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit((~^b) ^ par_flip);
      send_bit(stop);
      kbd_data = 1'b1;
      cycles(HALF);
   endtask

   // Watchdog
   initial begin
      #1_500_000;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // ---------------- stimulus ----------------
   initial begin
      cycles(5);
      check("rst_outputs", 32'({key_valid, overflow, parity_err, frame_err, key_ext, key_break, key_code}), 32'd0);
      check("rst_state", 32'(dut.state_q), 32'(IDLE));
      rst = 1'b0;
      cycles(10);

      // T1: single plain frame
      valid_cycles = 0; perr_cnt = 0; ferr_cnt = 0;
      exp_q.push_back({2'b00, 8'h1C});
      send_frame(8'h1C, 1'b0, 1'b1);
      cycles(10);
      check_events("t1_event", 1'b0);
      check("t1_valid_cycles", 32'(valid_cycles), 32'd1);
      check("t1_err_pulses", 32'(perr_cnt + ferr_cnt), 32'd0);

      // T2: E0 F0 75 folds into one event, flags then clear
      exp_q.push_back({2'b11, 8'h75});
      exp_q.push_back({2'b00, 8'h1C});
      send_frame(8'hE0, 1'b0, 1'b1);
      send_frame(8'hF0, 1'b0, 1'b1);
      send_frame(8'h75, 1'b0, 1'b1);
      send_frame(8'h1C, 1'b0, 1'b1);
      cycles(10);
      check_events("t2_event", 1'b0);
      check("t2_err_pulses", 32'(perr_cnt + ferr_cnt), 32'd0);

      // T3: parity error, then bad stop clearing a pending F0
      send_frame(8'h1C, 1'b1, 1'b1);
      cycles(10);
      check("t3_parity_pulse", 32'(perr_cnt), 32'd1);
      check("t3_no_frame_err", 32'(ferr_cnt), 32'd0);
      check_events("t3_no_event", 1'b0);
      exp_q.push_back({2'b00, 8'h1C});
      send_frame(8'hF0, 1'b0, 1'b1);
      send_frame(8'h33, 1'b0, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b1);
      cycles(10);
      check("t3_frame_pulse", 32'(ferr_cnt), 32'd1);
      check_events("t3_event", 1'b0);
      send_frame(8'h44, 1'b1, 1'b0);
      cycles(10);
      check("t3_both_frame", 32'(ferr_cnt), 32'd2);
      check("t3_both_parity", 32'(perr_cnt), 32'd1);

      // T4: aborted frame recovered by timeout
      ferr_cnt = 0;
      send_bit(1'b0);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      kbd_data = 1'b1;
      cycles(2000);
      check("t4_no_early_timeout", 32'(ferr_cnt), 32'd0);
      check("t4_state_data", 32'(dut.state_q), 32'(DATA));
      cycles(TO);
      check("t4_timeout_pulse", 32'(ferr_cnt), 32'd1);
      check("t4_state_idle", 32'(dut.state_q), 32'(IDLE));
      exp_q.push_back({2'b00, 8'h29});
      send_frame(8'h29, 1'b0, 1'b1);
      cycles(10);
      check_events("t4_event", 1'b0);

      // T5: overflow with FIFO_DEPTH+1 frames
      key_ready = 1'b0;
      for (int i = 1; i <= FD + 1; i++) send_frame(8'(i), 1'b0, 1'b1);
      cycles(10);
      check("t5_overflow", 32'(overflow), 32'd1);
      check("t5_valid_full", 32'(key_valid), 32'd1);
      check("t5_head", 32'({key_ext, key_break, key_code}), 32'h001);
      for (int i = 1; i <= FD; i++) exp_q.push_back({2'b00, 8'(i)});
      key_ready = 1'b1;
      cycles(20);
      check_events("t5_drain", 1'b0);
      check("t5_valid_empty", 32'(key_valid), 32'd0);

      // T5b: push and pop in the same cycle while full
      rst = 1'b1;
      cycles(3);
      rst = 1'b0;
      cycles(5);
      check("t5b_overflow_rst", 32'(overflow), 32'd0);
      key_ready = 1'b0;
      for (int i = 0; i < FD; i++) send_frame(8'h11 + 8'(i), 1'b0, 1'b1);
      check("t5b_full_no_ovf", 32'(overflow), 32'd0);
      pop_wait = 0;
      fork
         send_frame(8'h19, 1'b0, 1'b1);
         begin
            while (!(dut.fall_stb && dut.state_q == STOP) && pop_wait < 3000) begin
               @(negedge clk);
               pop_wait++;
            end
            if (pop_wait >= 3000) check("t5b_stop_seen", 32'd0, 32'd1);
            @(posedge clk); #1;
            key_ready = 1'b1;
            @(posedge clk); #1;
            key_ready = 1'b0;
         end
      join
      cycles(5);
      check("t5b_overflow", 32'(overflow), 32'd0);
      for (int i = 0; i <= FD; i++) exp_q.push_back({2'b00, 8'h11 + 8'(i)});
      key_ready = 1'b1;
      cycles(20);
      check_events("t5b_drain", 1'b0);

      // T6a: short kbd_clk glitch is filtered
      stb_snap = stb_cnt;
      kbd_data = 1'b0;
      kbd_clk  = 1'b0;
      cycles(DB - 10);
      kbd_clk  = 1'b1;
      cycles(100);
      kbd_data = 1'b1;
      check("t6_glitch_strobe", 32'(stb_cnt - stb_snap), 32'd0);
      check("t6_glitch_state", 32'(dut.state_q), 32'(IDLE));

      // T6b: raw stream on the DECODE=0 instance
      rst2 = 1'b0;
      cycles(5);
      exp2_q.push_back({2'b00, 8'hE0});
      exp2_q.push_back({2'b00, 8'h75});
      exp_q.push_back({2'b10, 8'h75});
      send_frame(8'hE0, 1'b0, 1'b1);
      send_frame(8'h75, 1'b0, 1'b1);
      cycles(10);
      check_events("t6_raw", 1'b1);
      check_events("t6_decoded", 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
